counter_seq_ctrl: RTL
=====================

// Module: counter_seq_ctrl
// PURPOSE
//   Run-control sequencer for the 4-digit 7-seg up/down counter datapath.
//   Turns two push-buttons and the board switches into load / direction / enable
//   commands for the counter, and watches the counter value fed back from it.
//   Stops the count at the terminal value and raises a timed alarm.
//   Sits between board I/O and the counter + display instance on the FPGA top.
// PARAMETERS
//   CMAX       20          counter modulus; legal values 0..CMAX-1; 2..256
//   ALARM_CYC  25_000_000  cycles alarm stays high in DONE (bench: 8)
// PORTS
//   CLK        in   1  system clock
//   RST        in   1  synchronous reset, active-high
//   btn_go     in   1  run/pause button, asynchronous, active-high
//   btn_load   in   1  load button, asynchronous, active-high
//   sw_dir     in   1  direction switch: 1 = down, 0 = up
//   sw_data    in   8  preset value from the switches
//   cnt_val    in   8  current binary count fed back from the counter
//   load       out  1  one-cycle load strobe to the counter
//   data_out   out  8  preset value to the counter (valid while load=1)
//   up_down    out  1  direction to the counter: 1 = down
//   cnt_en     out  1  counter tick enable
//   alarm      out  1  terminal-count alarm
//   state_o    out  3  FSM state code, for debug LEDs
// BEHAVIOUR
//   - Reset (RST=1 at an edge): state IDLE; all outputs 0; synchronizers and
//     alarm timer cleared. RST mid-RUN or mid-DONE aborts at that same edge.
//   - btn_go and btn_load each pass through a 2-FF synchronizer and then a
//     rising-edge detect (pulse = s2 & ~s3).
//   - A button high before edge 1 changes the state at edge 3. A held button
//     gives one pulse only.
//   - All outputs are registered and decoded from the next state, so they
//     change at the same edge as state_o.
//   - State codes: IDLE=0, LOAD=1, RUN=2, PAUSE=3, DONE=4.
//   - IDLE (outputs all 0):
//       load pulse -> LOAD
//       else go pulse -> RUN
//   - LOAD: stays exactly 1 cycle, then -> IDLE.
//       load=1; data_out = min(sw_data, CMAX-1), saturating.
//       cnt_en=0; up_down holds its previous value.
//   - RUN: cnt_en=1; up_down = sw_dir latched on every entry to RUN.
//     sw_dir changes while in RUN are ignored. Checks in priority order:
//       1) terminal count -> DONE
//          (up: cnt_val==CMAX-1; down: cnt_val==0)
//       2) go pulse -> PAUSE
//       3) load pulse is ignored
//   - PAUSE: cnt_en=0.
//       load pulse -> LOAD (wins over a simultaneous go pulse)
//       else go pulse -> RUN
//   - DONE: cnt_en=0; alarm=1.
//       Timer counts ALARM_CYC cycles, then -> IDLE with alarm=0.
//       go pulse -> IDLE early; timer clears.
//       load pulse is ignored.
//   - cnt_val >= CMAX is treated as a terminal value in both directions, so a
//     corrupt count stops the run instead of running away.
//   - Entering RUN already at the terminal value goes to DONE on the next edge.
//   - Alarm timer width: $clog2(ALARM_CYC+1) bits.
//   - No illegal state persists: codes 5..7 -> IDLE at the next edge.
// TESTING
//   1. RST=1 for 3 edges, then 0 -> state_o=0; load, cnt_en, alarm, data_out=0.
//   2. IDLE, sw_data=58, pulse btn_load ->
//        load=1 for exactly 1 cycle with data_out=19 (CMAX=20), then state_o=0.
//      Same test with sw_data=7 -> data_out=7.
//   3. IDLE, sw_dir=0, pulse btn_go -> state_o=2 at edge 3, cnt_en=1, up_down=0.
//      Drive cnt_val=19 -> next edge state_o=4, cnt_en=0, alarm=1 for 8 cycles,
//      then state_o=0.
//   4. RUN down, pulse btn_go -> PAUSE (cnt_en=0).
//      Toggle sw_dir to 0, pulse btn_go -> RUN with up_down=0.
//      Hold btn_go high 50 cycles -> exactly one transition.
//   5. PAUSE, btn_go and btn_load rise in the same cycle -> LOAD wins.
//      In RUN, cnt_val=0 (down) together with a go pulse -> DONE, not PAUSE.
//   6. Assert RST for 1 cycle during DONE with alarm high ->
//      next edge state_o=0, alarm=0. Force state code 6 -> IDLE next edge.

Source files
------------

// File: rtl/counter_seq_ctrl.sv
// Run-control sequencer for the 4-digit up/down counter: synchronizes the board
// buttons, drives load/direction/enable to the counter and times the terminal alarm.
module counter_seq_ctrl #(
   parameter int CMAX      = 20,
   parameter int ALARM_CYC = 25_000_000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       btn_go,
   input  logic       btn_load,
   input  logic       sw_dir,
   input  logic [7:0] sw_data,
   input  logic [7:0] cnt_val,
   output logic       load,
   output logic [7:0] data_out,
   output logic       up_down,
   output logic       cnt_en,
   output logic       alarm,
   output logic [2:0] state_o
);

   localparam int TW = $clog2(ALARM_CYC + 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LOAD  = 3'd1;
   localparam logic [2:0] RUN   = 3'd2;
   localparam logic [2:0] PAUSE = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   localparam logic [7:0]    TOP    = 8'(CMAX - 1);
   localparam logic [8:0]    LIMIT  = 9'(CMAX);
   localparam logic [TW-1:0] T_LAST = TW'(ALARM_CYC - 1);

   logic          r_go_s1, r_go_s2, r_go_s3;
   logic          r_ld_s1, r_ld_s2, r_ld_s3;
   logic [2:0]    r_state;
   logic [TW-1:0] r_timer;
   logic          r_load, r_up_down, r_cnt_en, r_alarm;
   logic [7:0]    r_data_out;

   logic          w_go_pulse, w_ld_pulse;
   logic          w_term;
   logic [7:0]    w_sat;
   logic [2:0]    w_next;
   logic          w_up_down;

   assign w_go_pulse = r_go_s2 & ~r_go_s3;
   assign w_ld_pulse = r_ld_s2 & ~r_ld_s3;

   // An out-of-range count is terminal in either direction so a corrupt value stops the run.
   assign w_term = ({1'b0, cnt_val} >= LIMIT) |
                   (r_up_down ? (cnt_val == 8'd0) : (cnt_val == TOP));

   assign w_sat = (sw_data > TOP) ? TOP : sw_data;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_ld_pulse)      w_next = LOAD;
            else if (w_go_pulse) w_next = RUN;
         end
         LOAD: w_next = IDLE;
         RUN: begin
            if (w_term)          w_next = DONE;
            else if (w_go_pulse) w_next = PAUSE;
         end
         PAUSE: begin
            if (w_ld_pulse)      w_next = LOAD;
            else if (w_go_pulse) w_next = RUN;
         end
         DONE: begin
            if (w_go_pulse || (r_timer == T_LAST)) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Direction is captured only on entry to RUN; IDLE forces it low.
   always_comb begin
      w_up_down = r_up_down;
      if (w_next == IDLE)
         w_up_down = 1'b0;
      else if ((w_next == RUN) && (r_state != RUN))
         w_up_down = sw_dir;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_go_s1    <= 1'b0;
         r_go_s2    <= 1'b0;
         r_go_s3    <= 1'b0;
         r_ld_s1    <= 1'b0;
         r_ld_s2    <= 1'b0;
         r_ld_s3    <= 1'b0;
         r_state    <= IDLE;
         r_timer    <= '0;
         r_load     <= 1'b0;
         r_data_out <= '0;
         r_up_down  <= 1'b0;
         r_cnt_en   <= 1'b0;
         r_alarm    <= 1'b0;
      end else begin
         r_go_s1    <= btn_go;
         r_go_s2    <= r_go_s1;
         r_go_s3    <= r_go_s2;
         r_ld_s1    <= btn_load;
         r_ld_s2    <= r_ld_s1;
         r_ld_s3    <= r_ld_s2;
         r_state    <= w_next;
         r_timer    <= ((r_state == DONE) && (w_next == DONE)) ? r_timer + TW'(1) : '0;
         r_load     <= (w_next == LOAD);
         r_data_out <= (w_next == LOAD) ? w_sat : 8'd0;
         r_up_down  <= w_up_down;
         r_cnt_en   <= (w_next == RUN);
         r_alarm    <= (w_next == DONE);
      end
   end

   assign load     = r_load;
   assign data_out = r_data_out;
   assign up_down  = r_up_down;
   assign cnt_en   = r_cnt_en;
   assign alarm    = r_alarm;
   assign state_o  = r_state;

endmodule
